// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for a single native memory port (valid/ready/addr/wdata/wstrb/rdata).
// The grant is held for one complete transaction. Requests are registered, so there is no
// combinational path from any mN_valid to mem_valid. An optional watchdog aborts a granted
// transaction that never sees mem_ready and returns ERR_DATA with a one-cycle bus_err.
module mem_bus_arbiter #(
  parameter bit          ROUND_ROBIN = 1'b1,
  parameter int unsigned TIMEOUT     = 0,
  parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        bus_err,
  output logic        owner
);

  localparam bit          WdEn    = (TIMEOUT > 0);
  localparam int unsigned CntW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic StIdle = 1'b0;
  localparam logic StBusy = 1'b1;

  logic            state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic            bus_err_q, bus_err_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic            win;
  logic            busy;

  // Winner selection among the currently requesting masters.
  always_comb begin
    if (m0_valid && m1_valid) begin
      win = ROUND_ROBIN ? ~last_q : 1'b0;
    end else begin
      win = m1_valid;
    end
  end

  // Next-state: grant in IDLE, complete or time out in BUSY.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bus_err_d = 1'b0;
    if (state_q == StIdle) begin
      // The abort-response cycle is held off so the aborted owner can drop its request first.
      if ((m0_valid || m1_valid) && !bus_err_q) begin
        state_d = StBusy;
        owner_d = win;
        last_d  = win;
        cnt_d   = '0;
        addr_d  = win ? m1_addr  : m0_addr;
        wdata_d = win ? m1_wdata : m0_wdata;
        wstrb_d = win ? m1_wstrb : m0_wstrb;
      end
    end else if (mem_ready) begin
      // mem_ready wins over a coinciding watchdog expiry.
      state_d = StIdle;
    end else if (WdEn && (cnt_q == CntLast)) begin
      state_d   = StIdle;
      bus_err_d = 1'b1;
    end else if (WdEn) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      bus_err_q <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      bus_err_q <= bus_err_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  // Outputs: downstream request from registers, completion strobes steered to the owner.
  always_comb begin
    busy      = (state_q == StBusy);
    mem_valid = busy;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_wstrb = wstrb_q;
    bus_err   = bus_err_q;
    owner     = owner_q;
    m0_ready  = !owner_q && ((busy && mem_ready) || bus_err_q);
    m1_ready  = owner_q && ((busy && mem_ready) || bus_err_q);
    m0_rdata  = owner_q ? 32'h0 : (bus_err_q ? ERR_DATA : mem_rdata);
    m1_rdata  = owner_q ? (bus_err_q ? ERR_DATA : mem_rdata) : 32'h0;
  end

endmodule
